db_level_filter: RTL and testbench

//  Debounce/synchronise stage feeding the dual edge detector.
//  - Takes a raw asynchronous switch/button input and synchronises it into clk.
//  - Drives a clean 'level' only after the input has been stable for DB_TICKS cycles.
//  - Flags and counts aborted (bouncing) transitions for diagnostics.

---
 rtl/db_level_filter.sv | 155 +++++++++++++++
 tb/tb_db_level_filter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/db_level_filter.sv
// ---------------------------------------------------------------------------
// db_level_filter
//   Debounce and synchronise stage feeding the dual edge detector. A raw
//   asynchronous switch input is brought into the clk domain through a
//   two-flop synchroniser. The debounced 'level' changes only after the
//   synchronised input has been stable for DB_TICKS cycles. Transitions that
//   are abandoned before they qualify are flagged and counted for diagnostics.
//
// Parameters
//   CNT_W      width of the stability counter
//   DB_TICKS   stable cycles required before level changes (1 .. 2**CNT_W-1)
//
// Ports
//   clk         in   system clock, all logic on posedge
//   reset_n     in   asynchronous active-low reset
//   sw          in   raw asynchronous switch input
//   level       out  debounced level (registered)
//   busy        out  high while a transition is being qualified
//   bounce      out  one-cycle pulse after a pending transition is aborted
//   bounce_cnt  out  saturating count of aborted transitions
// ---------------------------------------------------------------------------
module db_level_filter #(
  parameter int CNT_W    = 20,
  parameter int DB_TICKS = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sw,
  output logic       level,
  output logic       busy,
  output logic       bounce,
  output logic [7:0] bounce_cnt
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DB_TICKS - 1);

  // Saturating 8-bit increment for the abort counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  logic             s1_r;
  logic             s2_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             abort_s;
  logic             level_r;
  logic             busy_r;
  logic             bounce_r;
  logic [7:0]       bounce_cnt_r;

  // Two-flop synchroniser; s2_r is the only consumer-visible copy of sw.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= sw;
      s2_r <= s1_r;
    end
  end

  // Next-state logic; the input is checked before the counter so an abort
  // always wins over a completion landing on the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    abort_s     = 1'b0;
    case (state_r)
      ZERO: begin
        if (s2_r) begin
          state_nxt_s = WAIT1;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ZERO;
        end
      end
      WAIT1: begin
        if (!s2_r) begin
          state_nxt_s = ZERO;
          abort_s     = 1'b1;
        end else if (cnt_r == LAST_CNT) begin
          state_nxt_s = ONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ONE: begin
        if (!s2_r) begin
          state_nxt_s = WAIT0;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ONE;
        end
      end
      WAIT0: begin
        if (s2_r) begin
          state_nxt_s = ONE;
          abort_s     = 1'b1;
        end else if (cnt_r == LAST_CNT) begin
          state_nxt_s = ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ZERO;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; level/busy are registered copies
  // of the decode of the state being entered, so they track state_r exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ZERO;
      cnt_r        <= '0;
      level_r      <= 1'b0;
      busy_r       <= 1'b0;
      bounce_r     <= 1'b0;
      bounce_cnt_r <= 8'd0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      level_r  <= (state_nxt_s == ONE) || (state_nxt_s == WAIT0);
      busy_r   <= (state_nxt_s == WAIT1) || (state_nxt_s == WAIT0);
      bounce_r <= abort_s;
      if (abort_s) begin
        bounce_cnt_r <= sat_inc8(bounce_cnt_r);
      end else begin
        bounce_cnt_r <= bounce_cnt_r;
      end
    end
  end

  assign level      = level_r;
  assign busy       = busy_r;
  assign bounce     = bounce_r;
  assign bounce_cnt = bounce_cnt_r;

endmodule

// File: tb/tb_db_level_filter.sv
// ---------------------------------------------------------------------------
// tb_db_level_filter
//   Directed, table-driven bench for db_level_filter with CNT_W=3 and
//   DB_TICKS=4. Table rows are indexed by posedge number after reset release
//   (row i = edge i+1); each row gives sw for that edge and the outputs
//   expected just after it. Reset-in-WAIT and counter saturation are
//   hand-written sequences.
// ---------------------------------------------------------------------------
module tb_db_level_filter;

  logic       clk;
  logic       reset_n;
  logic       sw;
  logic       level;
  logic       busy;
  logic       bounce;
  logic [7:0] bounce_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       sw;
    logic       level;
    logic       busy;
    logic       bounce;
    logic [7:0] cnt;
  } vec_t;

  localparam int NVEC = 46;
  vec_t vecs [NVEC];

  db_level_filter #(
    .CNT_W   (3),
    .DB_TICKS(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw        (sw),
    .level     (level),
    .busy      (busy),
    .bounce    (bounce),
    .bounce_cnt(bounce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic l, input logic b,
                              input logic bo, input logic [7:0] c);
    vec_t v;
    v.sw = s; v.level = l; v.busy = b; v.bounce = bo; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_all(input string name, input logic l, input logic b,
                         input logic bo, input logic [7:0] c);
    chk({name, ".level"},  {7'd0, level},  {7'd0, l});
    chk({name, ".busy"},   {7'd0, busy},   {7'd0, b});
    chk({name, ".bounce"}, {7'd0, bounce}, {7'd0, bo});
    chk({name, ".cnt"},    bounce_cnt,     c);
  endtask

  // Drive sw, advance one posedge, land 1 time unit after it.
  task automatic step(input logic s);
    sw = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // edge: sw, level, busy, bounce, bounce_cnt
    // reset released with sw=1: fresh rise, busy after edges 3-6, level at 7
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    // clean fall sampled at edge 8 -> level 0 at edge 14
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    // sw high two cycles then low: abort at edge 19
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    // clean rise sampled at edge 21 -> level 1 at edge 27
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    vecs[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    vecs[22] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    vecs[23] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    vecs[24] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    vecs[25] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    vecs[26] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    // in ONE: one-cycle low glitch at edge 28 -> abort at edge 31
    vecs[27] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    vecs[28] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    vecs[29] = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
    vecs[30] = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    // then low held from edge 32 -> level 0 at edge 38
    vecs[31] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    vecs[32] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    vecs[33] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    vecs[34] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    vecs[35] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    vecs[36] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    vecs[37] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    // abort landing when cnt==DB_TICKS-1: abort wins, no level change
    vecs[38] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    vecs[39] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    vecs[40] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    vecs[41] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    vecs[42] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    vecs[43] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    vecs[44] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    vecs[45] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);

    // Reset held with sw=1: everything stays 0.
    reset_n = 1'b0;
    sw      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk_all("in_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    #2 reset_n = 1'b1;  // release between edges

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].sw);
      chk_all($sformatf("vec%0d", i + 1), vecs[i].level, vecs[i].busy,
              vecs[i].bounce, vecs[i].cnt);
    end

    // Reset asserted while in WAIT1: immediate return to idle, counter cleared.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk_all("pre_rst_wait1", 1'b0, 1'b1, 1'b0, 8'd3);
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    sw = 1'b0;
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk_all("post_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // 300 aborted rises: counter saturates at 255, level never rises.
    for (int it = 0; it < 300; it++) begin
      step(1'b1);
      chk("sat.level0", {7'd0, level}, 8'd0);
      chk("sat.bounce_idle", {7'd0, bounce}, 8'd0);
      step(1'b0);
      step(1'b0);
      chk("sat.busy", {7'd0, busy}, 8'd1);
      step(1'b0);
      chk("sat.level3", {7'd0, level}, 8'd0);
      chk("sat.bounce", {7'd0, bounce}, 8'd1);
      chk("sat.cnt", bounce_cnt, (it + 1 >= 255) ? 8'd255 : 8'(it + 1));
    end
    step(1'b0);
    chk_all("sat_final", 1'b0, 1'b0, 1'b0, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
